multi_fx_pipe: RTL and testbench

//   Parametrised, 3-stage pipelined signed fixed-point multiplier for the FFT butterfly datapath.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/multi_abs.sv | 17 +
 rtl/multi_fx_pipe.sv | 127 ++++++++++++
 tb/tb_multi_fx_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths and saturation helpers for the FFT datapath
//
// Purpose : default sample/coefficient/fraction widths for the butterfly
//           multiplier and helpers returning the saturation bounds of a
//           w-bit two's-complement value.
//   sat_max(w) : 2^(w-1)-1, largest positive value
//   sat_min(w) : 2^(w-1), magnitude of the most negative value
package fft_pkg;

    localparam int FFT_DATA_W = 17;
    localparam int FFT_COEF_W = 8;
    localparam int FFT_FRAC_W = 7;

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/multi_abs.sv
// rtl/multi_abs.sv - two's-complement to unsigned magnitude
//
// Purpose : combinational absolute value. The W-bit unsigned result holds
//           the magnitude of -2^(W-1) exactly (it becomes 2^(W-1)).
// Ports   :
//   val_i  in  W  two's-complement operand
//   mag_o  out W  unsigned magnitude
module multi_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] val_i,
    output logic [W-1:0] mag_o
);

    assign mag_o = val_i[W-1] ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/multi_fx_pipe.sv
// rtl/multi_fx_pipe.sv - 3-stage saturating signed fixed-point multiplier
//
// Purpose : out = sat(in_data * in_coef / 2^FRAC_W) with valid/ready flow
//           control; sign-magnitude datapath so truncation (or rounding)
//           is symmetric about zero.
// Config  : MULTI_FX_ROUND_EN defined -> round half away from zero,
//           otherwise truncate the magnitude. Timing is identical.
// Ports   :
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       operand pair valid
//   in_ready   out  1       operand pair accepted this cycle
//   in_data    in   DATA_W  sample
//   in_coef    in   COEF_W  fractional coefficient
//   out_valid  out  1       result valid
//   out_ready  in   1       downstream accepts result
//   out_data   out  DATA_W  scaled, saturated product
//   out_ovf    out  1       result was saturated
module multi_fx_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int COEF_W = FFT_COEF_W,
    parameter int FRAC_W = FFT_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    localparam int PW = DATA_W + COEF_W;

    // One extra bit so the rounding add cannot wrap.
    localparam logic [PW:0] LIM_POS = (PW+1)'(sat_max(DATA_W));
    localparam logic [PW:0] LIM_NEG = (PW+1)'(sat_min(DATA_W));
`ifdef MULTI_FX_ROUND_EN
    localparam logic [PW:0] RND_ADD = (PW+1)'(64'd1 << (FRAC_W - 1));
`else
    localparam logic [PW:0] RND_ADD = '0;
`endif

    logic              advance;
    logic [DATA_W-1:0] mag_a;
    logic [COEF_W-1:0] mag_b;

    logic              v1_q, v1_d, sign1_q, sign1_d;
    logic [DATA_W-1:0] a1_q, a1_d;
    logic [COEF_W-1:0] b1_q, b1_d;

    logic              v2_q, v2_d, sign2_q, sign2_d;
    logic [PW-1:0]     prod2_q, prod2_d;

    logic              v3_q, v3_d, ovf3_q, ovf3_d;
    logic [DATA_W-1:0] data3_q, data3_d;

    logic [PW:0]       mag_sum, mag_s, limit;

    // The whole pipe moves as one; a full output stage that is not being
    // drained stalls every stage behind it.
    assign advance  = ~v3_q | out_ready;
    assign in_ready = advance;

    multi_abs #(.W(DATA_W)) u_abs_data (.val_i(in_data), .mag_o(mag_a));
    multi_abs #(.W(COEF_W)) u_abs_coef (.val_i(in_coef), .mag_o(mag_b));

    always_comb begin
        v1_d    = in_valid;
        sign1_d = in_data[DATA_W-1] ^ in_coef[COEF_W-1];
        a1_d    = mag_a;
        b1_d    = mag_b;

        v2_d    = v1_q;
        sign2_d = sign1_q;
        prod2_d = PW'(a1_q) * PW'(b1_q);

        mag_sum = {1'b0, prod2_q} + RND_ADD;
        mag_s   = mag_sum >> FRAC_W;
        // Negative results reach one further than positive ones.
        limit   = sign2_q ? LIM_NEG : LIM_POS;
        v3_d    = v2_q;
        ovf3_d  = mag_s > limit;
        if (ovf3_d) begin
            data3_d = sign2_q ? LIM_NEG[DATA_W-1:0] : LIM_POS[DATA_W-1:0];
        end else begin
            // Negating a zero magnitude yields zero, so no negative zero.
            data3_d = sign2_q ? -mag_s[DATA_W-1:0] : mag_s[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            prod2_q <= '0;
            v3_q    <= 1'b0;
            ovf3_q  <= 1'b0;
            data3_q <= '0;
        end else if (advance) begin
            v1_q    <= v1_d;
            sign1_q <= sign1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            v2_q    <= v2_d;
            sign2_q <= sign2_d;
            prod2_q <= prod2_d;
            v3_q    <= v3_d;
            ovf3_q  <= ovf3_d;
            data3_q <= data3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_data  = data3_q;
    assign out_ovf   = ovf3_q;

endmodule

// File: tb/tb_multi_fx_pipe.sv
// tb/tb_multi_fx_pipe.sv - self-checking bench for multi_fx_pipe
module tb_multi_fx_pipe;

`ifdef MULTI_FX_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_data;
    logic [7:0]  in_coef;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    multi_fx_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_coef(in_coef),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int exp;
        bit ovf;
    } vec_t;

    vec_t        vecs[13];
    logic [17:0] expq[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the sign and magnitudes.
    function automatic logic [17:0] model(input logic [16:0] a, input logic [7:0] b);
        longint sa, sb, m, lim, d;
        bit     s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = (sa < 0) != (sb < 0);
        m   = (sa < 0 ? -sa : sa) * (sb < 0 ? -sb : sb);
        if (RND) m = m + 64;
        m   = m / 128;
        lim = s ? 65536 : 65535;
        if (m > lim) return {1'b1, (s ? 17'h10000 : 17'h0FFFF)};
        d = s ? -m : m;
        return {1'b0, 17'(d)};
    endfunction

    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 17'(vecs[i].a);
        in_coef   = 8'(vecs[i].b);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("vec%0d_latency", i), lat, 3);
        check($sformatf("vec%0d_data", i), $signed(out_data), vecs[i].exp);
        check($sformatf("vec%0d_ovf", i), out_ovf, vecs[i].ovf);
    endtask

    // rand_mode=0: continuous input with a 4-cycle output stall;
    // rand_mode=1: random in_valid / out_ready.
    task automatic run_stream(input int n, input bit rand_mode, input string tag);
        int          idx = 0;
        int          got = 0;
        int          cyc = 0;
        bit          took = 1'b0;
        logic [16:0] held = '0;
        logic [17:0] e;
        in_valid = 1'b0;
        while ((idx < n || got < n) && cyc < n * 4 + 200) begin
            @(negedge clk);
            if (took) begin
                idx++;
                took     = 1'b0;
                in_valid = 1'b0;
            end
            if (idx < n && !in_valid) begin
                if (!rand_mode || $urandom_range(3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = 17'($urandom);
                    in_coef  = 8'($urandom);
                end
            end
            if (rand_mode) out_ready = ($urandom_range(3) != 0);
            else           out_ready = !(cyc >= 6 && cyc < 10);
            #1;
            if (!rand_mode && cyc == 6) held = out_data;
            if (!rand_mode && cyc > 6 && cyc < 10) begin
                check($sformatf("%s_stall_in_ready_c%0d", tag, cyc), in_ready, 0);
                check($sformatf("%s_stall_hold_c%0d", tag, cyc), out_data, held);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check($sformatf("%s_extra_output", tag), 1, 0);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("%s_data%0d", tag, got), $signed(out_data), $signed(e[16:0]));
                    check($sformatf("%s_ovf%0d", tag, got), out_ovf, e[17]);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(in_data, in_coef));
                took = 1'b1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check($sformatf("%s_count", tag), got, n);
        check($sformatf("%s_leftover", tag), expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        vecs[0]  = '{1000, 64, 500, 1'b0};
        vecs[1]  = '{-1000, 64, -500, 1'b0};
        vecs[2]  = '{-1000, -64, 500, 1'b0};
        vecs[3]  = '{3, 64, (RND ? 2 : 1), 1'b0};
        vecs[4]  = '{-3, 64, (RND ? -2 : -1), 1'b0};
        vecs[5]  = '{-65536, -128, 65535, 1'b1};
        vecs[6]  = '{-65536, 127, -65024, 1'b0};
        vecs[7]  = '{65535, -128, -65535, 1'b0};
        vecs[8]  = '{0, -128, 0, 1'b0};
        vecs[9]  = '{-1, 1, 0, 1'b0};
        vecs[10] = '{1, 64, (RND ? 1 : 0), 1'b0};
        vecs[11] = '{-1, 64, (RND ? -1 : 0), 1'b0};
        vecs[12] = '{65535, 127, 65023, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_coef   = '0;
        out_ready = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_ovf", out_ovf, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i);

        run_stream(10, 1'b0, "stall");

        // Three results in flight, then reset.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 17'(1000 + i);
            in_coef  = 8'd64;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre_reset_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("reset_async_out_valid", out_valid, 0);
        check("reset_async_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", i), out_valid, 0);
        end

        run_stream(10000, 1'b1, "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
